// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB response codes, slave FSM states and master-number width.
package ahb_pkg;
  localparam int MAST_W = 2;
  typedef enum logic [1:0] {RESP_OKAY, RESP_ERROR, RESP_RETRY, RESP_SPLIT} resp_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP1, ST_RESP2} state_t;
endpackage

// File: rtl/ahb_split_tracker.sv
// ahb_split_tracker: single pending SPLIT entry, latency counter and hsplit pulse.
module ahb_split_tracker
  import ahb_pkg::*;
#(
  parameter int LAT = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              req,
  input  logic [MAST_W-1:0] req_mast,
  output logic              split,
  output logic              retry,
  output logic              hsplit,
  output logic [MAST_W-1:0] hsplit_mast
);
  logic              valid, same;
  logic [MAST_W-1:0] mast;
  logic [7:0]        cnt;
  assign same  = (mast == req_mast);
  assign retry = valid & ~same;
  assign split = ~valid | (same & (cnt != 8'd0));
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      valid       <= 1'b0;
      mast        <= '0;
      cnt         <= '0;
      hsplit      <= 1'b0;
      hsplit_mast <= '0;
    end else begin
      hsplit      <= valid && cnt == 8'd1;
      hsplit_mast <= (valid && cnt == 8'd1) ? mast : '0;
      if (req && !valid) begin
        valid <= 1'b1;
        mast  <= req_mast;
        cnt   <= 8'(LAT);
      end else begin
        // entry survives the pulse and is only retired by the owner's retry
        if (req && same && cnt == 8'd0) valid <= 1'b0;
        if (cnt != 8'd0) cnt <= cnt - 8'd1;
      end
    end
endmodule

// File: rtl/ahb_split_slave.sv
// ahb_split_slave: AHB slave with word memory, wait states and ERROR response;
// SPLIT/RETRY support is built in when AHB_SLV_SPLIT_EN is defined.
module ahb_split_slave
  import ahb_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_CYCLES = 1,
  parameter int unsigned SPLIT_BASE  = 32'hC0,
  parameter int          SPLIT_LAT   = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic              htrans,
  input  logic              hwrite,
  input  logic [MAST_W-1:0] hmaster,
  input  logic [31:0]       haddr_mux_out,
  input  logic [31:0]       hwdata_mux_out,
  input  logic              hready_in,
  output logic [31:0]       hrdata,
  output logic              hready,
  output logic [1:0]        hresp,
  output logic              hsplit,
  output logic [MAST_W-1:0] hsplit_mast
);
  logic [31:0]       mem [2**ADDR_W];
  state_t            state, state_n;
  resp_t             code, code_n, code_in;
  logic [3:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] idx, idx_n, idx_in;
  logic              wr, wr_n, pend, pend_n, acc, err, sp_hit, rt_hit;
  logic              hready_n, unused_ok;
  logic [1:0]        hresp_n;
  logic [31:0]       hrdata_n, rd_word;
  assign acc       = hsel & htrans & hready_in & (state == ST_IDLE);
  assign idx_in    = haddr_mux_out[ADDR_W+1:2];
  assign err       = |haddr_mux_out[31:ADDR_W+2];
  assign unused_ok = ^{hmaster, haddr_mux_out[1:0]};
`ifdef AHB_SLV_SPLIT_EN
  logic in_split, sp, rt;
  assign in_split = acc & ~err & (32'(idx_in) >= SPLIT_BASE);
  assign sp_hit   = in_split & sp;
  assign rt_hit   = in_split & rt;
  ahb_split_tracker #(.LAT(SPLIT_LAT)) u_trk (
    .hclk, .hresetn, .req(in_split), .req_mast(hmaster),
    .split(sp), .retry(rt), .hsplit, .hsplit_mast
  );
`else
  assign sp_hit      = 1'b0;
  assign rt_hit      = 1'b0;
  assign hsplit      = 1'b0;
  assign hsplit_mast = '0;
`endif
  assign code_in = err ? RESP_ERROR : rt_hit ? RESP_RETRY : sp_hit ? RESP_SPLIT : RESP_OKAY;
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      state  <= ST_IDLE;
      code   <= RESP_OKAY;
      cnt    <= '0;
      idx    <= '0;
      wr     <= 1'b0;
      pend   <= 1'b0;
      hready <= 1'b1;
      hresp  <= RESP_OKAY;
      hrdata <= '0;
    end else begin
      state  <= state_n;
      code   <= code_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      wr     <= wr_n;
      pend   <= pend_n;
      hready <= hready_n;
      hresp  <= hresp_n;
      hrdata <= hrdata_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = 1'b0;
    idx_n   = acc ? idx_in : idx;
    wr_n    = acc ? hwrite : wr;
    code_n  = acc ? code_in : code;
    case (state)
      ST_IDLE:
        if (acc) begin
          if (code_in != RESP_OKAY) state_n = ST_RESP1;
          else if (WAIT_CYCLES == 0) pend_n = 1'b1;
          else begin
            state_n = ST_WAIT;
            cnt_n   = 4'(WAIT_CYCLES);
          end
        end
      ST_WAIT:
        if (cnt == 4'd1) begin
          state_n = ST_IDLE;
          pend_n  = 1'b1;
        end else cnt_n = cnt - 4'd1;
      ST_RESP1: state_n = ST_RESP2;
      default:  state_n = ST_IDLE;
    endcase
  end
  // a read pipelined behind a write to the same word sees the new data
  assign rd_word = (pend && wr && idx == idx_n) ? hwdata_mux_out : mem[idx_n];
  always_comb begin
    hready_n = (state_n != ST_WAIT) && (state_n != ST_RESP1);
    hresp_n  = (state_n == ST_RESP1 || state_n == ST_RESP2) ? code_n : RESP_OKAY;
    hrdata_n = (pend_n && !wr_n) ? rd_word : '0;
  end
  always_ff @(posedge hclk)
    if (pend && wr) mem[idx] <= hwdata_mux_out;
endmodule

// File: tb/tb_ahb_split_slave.sv
// tb_ahb_split_slave: directed checks of a 1-wait-state and a 0-wait-state slave instance.
module tb_ahb_split_slave;
  logic        hclk = 0, hresetn = 0, hsel_a = 0, hsel_b = 0, htrans = 0, hwrite = 0;
  logic [1:0]  hmaster = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [31:0] hrdata_a, hrdata_b;
  logic        hready_a, hready_b, hsplit_a, hsplit_b;
  logic [1:0]  hresp_a, hresp_b, hsm_a, hsm_b;
  int          n_vec = 0, n_err = 0;
  logic [31:0] pd [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
  int          rord [4] = '{3, 0, 1, 2};
  always #5 hclk = ~hclk;
  ahb_split_slave #(.WAIT_CYCLES(1)) ua (
    .hclk, .hresetn, .hsel(hsel_a), .htrans, .hwrite, .hmaster,
    .haddr_mux_out(haddr), .hwdata_mux_out(hwdata), .hready_in(hready_a),
    .hrdata(hrdata_a), .hready(hready_a), .hresp(hresp_a), .hsplit(hsplit_a), .hsplit_mast(hsm_a)
  );
  ahb_split_slave #(.WAIT_CYCLES(0)) ub (
    .hclk, .hresetn, .hsel(hsel_b), .htrans, .hwrite, .hmaster,
    .haddr_mux_out(haddr), .hwdata_mux_out(hwdata), .hready_in(hready_b),
    .hrdata(hrdata_b), .hready(hready_b), .hresp(hresp_b), .hsplit(hsplit_b), .hsplit_mast(hsm_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one-wait-state OKAY transfer on ua, issued and finished at a falling edge
  task automatic xa(input logic [1:0] m, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    hmaster = m; hsel_a = 1; htrans = 1; hwrite = w; haddr = a;
    @(negedge hclk);
    chk("wait_rdy", hready_a, 0);
    hsel_a = 0; htrans = 0; hwdata = d;
    @(negedge hclk);
    chk("cmp_rdy", hready_a, 1);
    chk("cmp_resp", hresp_a, 0);
    if (!w) chk("cmp_rdata", hrdata_a, exp);
    @(negedge hclk);
    chk("rdata_idle", hrdata_a, 0);
  endtask
  task automatic xresp(input logic [1:0] m, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] code);
    hmaster = m; hsel_a = 1; htrans = 1; hwrite = w; haddr = a;
    @(negedge hclk);
    chk("resp1_rdy", hready_a, 0);
    chk("resp1_code", hresp_a, code);
    hsel_a = 0; htrans = 0; hwdata = d;
    @(negedge hclk);
    chk("resp2_rdy", hready_a, 1);
    chk("resp2_code", hresp_a, code);
  endtask
  task automatic wait_split(input int c0, input logic [1:0] m);
    int c = c0;
    do begin
      @(negedge hclk);
      c++;
    end while (!hsplit_a && c < 60);
    chk("hsplit_cycle", c, 17);
    chk("hsplit_mast", hsm_a, m);
    @(negedge hclk);
    chk("hsplit_pulse", hsplit_a, 0);
  endtask
  initial begin
    repeat (2) @(negedge hclk);
    chk("rst_rdy", hready_a, 1);
    chk("rst_resp", hresp_a, 0);
    chk("rst_rdata", hrdata_a, 0);
    chk("rst_hsplit", hsplit_a, 0);
    chk("rst_smast", hsm_a, 0);
    chk("rst_rdy_b", hready_b, 1);
    hresetn = 1;
    @(negedge hclk);
    xa(0, 1, 32'h10, 32'hDEADBEEF, 0);
    xa(0, 0, 32'h10, 0, 32'hDEADBEEF);
    xa(0, 1, 32'h0, 32'h0BADF00D, 0);
    xresp(0, 1, 32'h0000_1000, 32'h1234_5678, 2'b01);
    @(negedge hclk);
    chk("err_after_resp", hresp_a, 0);
    chk("err_after_rdy", hready_a, 1);
    xa(0, 0, 32'h0, 0, 32'h0BADF00D);
    for (int j = 0; j <= 8; j++) begin
      if (j >= 1) chk("pipe_rdy", hready_b, 1);
      if (j >= 1) chk("pipe_resp", hresp_b, 0);
      if (j >= 5) chk("pipe_rdata", hrdata_b, pd[rord[j-5]]);
      hsel_b = (j < 8); htrans = (j < 8); hwrite = (j < 4);
      haddr  = 32'(j < 4 ? j : rord[(j-4) & 3]) << 2;
      hwdata = (j >= 1 && j <= 4) ? pd[j-1] : 32'h0;
      @(negedge hclk);
    end
`ifdef AHB_SLV_SPLIT_EN
    xresp(2, 1, 32'h310, 32'hCAFE_F00D, 2'b11);
    wait_split(2, 2);
    xa(2, 1, 32'h310, 32'hCAFE_F00D, 0);
    xresp(2, 0, 32'h310, 0, 2'b11);
    @(negedge hclk);
    xresp(1, 0, 32'h320, 0, 2'b10);
    wait_split(5, 2);
    xa(2, 0, 32'h310, 0, 32'hCAFE_F00D);
`else
    xa(2, 1, 32'h310, 32'hCAFE_F00D, 0);
    xa(2, 0, 32'h310, 0, 32'hCAFE_F00D);
    chk("nosplit_hsplit", hsplit_a, 0);
    chk("nosplit_smast", hsm_a, 0);
`endif
    hmaster = 0; hsel_a = 1; htrans = 1; hwrite = 1; haddr = 32'h10;
    @(negedge hclk);
    chk("rstw_wait", hready_a, 0);
    hsel_a = 0; htrans = 0; hwdata = 32'h1111_1111; hresetn = 0;
    #1;
    chk("rstw_rdy", hready_a, 1);
    chk("rstw_resp", hresp_a, 0);
    chk("rstw_rdata", hrdata_a, 0);
    chk("rstw_hsplit", hsplit_a, 0);
    @(negedge hclk);
    hresetn = 1;
    @(negedge hclk);
    xa(0, 0, 32'h10, 0, 32'hDEADBEEF);
`ifdef AHB_SLV_SPLIT_EN
    begin
      int hits = 0;
      xresp(2, 0, 32'h330, 0, 2'b11);
      hresetn = 0;
      @(negedge hclk);
      hresetn = 1;
      for (int i = 0; i < 30; i++) begin
        @(negedge hclk);
        if (hsplit_a) hits++;
      end
      chk("rst_split_none", hits, 0);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ahb_split_slave.md
# ahb_split_slave

AHB responder (slave) with on-chip word memory, programmable wait states, two-cycle ERROR response, and optional SPLIT completion. Occupies one slave slot on the shared bus. Receives `hsel` from the decoder and address/control/write data from the address and write-data muxes. Returns `hrdata`/`hready` to the read-data mux, `hresp` to the masters, and `hsplit`/`hsplit_mast` to the arbiter.

## Interface
- `ADDR_W`, 8: memory word-index width; depth is 2^ADDR_W × 32-bit words.
- `WAIT_CYCLES`, 1: wait states inserted before an OKAY completion (0–15).
- `SPLIT_BASE`, 8'hC0: word indices ≥ this value are the split region.
- `SPLIT_LAT`, 16: cycles from a SPLIT response to the `hsplit` pulse (1–255).
- `hclk` in 1: bus clock; all logic on the rising edge.
- `hresetn` in 1: asynchronous, active-low reset.
- `hsel` in 1: slave select from the decoder.
- `htrans` in 1: 1 = active transfer, 0 = idle.
- `hwrite` in 1: 1 = write, 0 = read.
- `hmaster` in 2: owning master number, from the arbiter.
- `haddr_mux_out` in 32: byte address; word index = `[ADDR_W+1:2]`.
- `hwdata_mux_out` in 32: write data, sampled in the data phase.
- `hready_in` in 1: bus-level `hready` (read-data mux output).
- `hrdata` out 32: read data.
- `hready` out 1: 1 = transfer complete.
- `hresp` out 2: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- `hsplit` out 1: one-cycle pulse telling the arbiter the split master may be re-granted.
- `hsplit_mast` out 2: master number qualified by `hsplit`.

## Operation
- **Address phase accept:** on a rising edge with `hsel & htrans & hready_in` = 1, latch word index, `hwrite` and `hmaster`, then classify:
  - `haddr_mux_out[31:ADDR_W+2]` ≠ 0 → ERROR.
  - Word index ≥ `SPLIT_BASE` with split logic built in → split path (below).
  - Otherwise → normal.
- **FSM states:** IDLE, WAIT, RESP1, RESP2.
- **IDLE:** `hready` = 1, `hresp` = OKAY.
  - Accept normal with `WAIT_CYCLES` = 0 → stay in IDLE; the next cycle is the completion cycle.
  - Accept normal with `WAIT_CYCLES` > 0 → WAIT; load the wait counter with `WAIT_CYCLES`.
  - Accept ERROR, SPLIT or RETRY → RESP1.
- **WAIT:** `hready` = 0, `hresp` = OKAY. The counter decrements each cycle. When it reaches 1, go to IDLE; that next cycle is the completion cycle.
- **Completion cycle:** `hready` = 1, `hresp` = OKAY.
  - Write: memory[index] ← `hwdata_mux_out` at the end of the cycle.
  - Read: `hrdata` = memory[index] during the cycle.
  - A new accept in the same cycle is pipelined normally.
- **RESP1:** `hready` = 0, `hresp` = code, then → RESP2.
- **RESP2:** `hready` = 1, `hresp` = code, then → IDLE. The slave ignores new accepts during RESP1/RESP2. No memory write occurs on a non-OKAY response.
- **`hrdata` outside read completion cycles:** holds 0.
- **Split path** (one pending entry: valid flag, master, latency counter):
  - No entry pending → respond SPLIT, store `hmaster`, load counter with `SPLIT_LAT`.
  - Entry pending, requester ≠ stored master → respond RETRY.
  - Entry pending, requester = stored master, counter expired → treat as normal (wait states, OKAY) and clear the entry.
  - Entry pending, requester = stored master, counter not expired → respond SPLIT again and keep the counter running.
  - When the counter reaches 0: `hsplit` = 1 for exactly one cycle, `hsplit_mast` = stored master; the entry stays valid until the retry completes.
- **Reset mid-operation:** the FSM returns to IDLE, the split entry and counters clear, and an in-flight write is dropped. Memory contents are not reset.

## Timing
- **Reset values:** `hready` = 1, `hresp` = 00, `hrdata` = 0, `hsplit` = 0, `hsplit_mast` = 0.
- **OKAY latency:** completion occurs `WAIT_CYCLES` + 1 cycles after the accept edge.
- **Two-cycle non-OKAY responses:** RESP1 and RESP2 follow the accept edge directly.
- **`hsplit` pulse:** asserted `SPLIT_LAT` cycles after the RESP1 cycle of the original SPLIT.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`AHB_SLV_SPLIT_EN` defined:** split-path logic, `hsplit` and `hsplit_mast` are active as described.
- **`AHB_SLV_SPLIT_EN` undefined:** split-region addresses are handled as normal OKAY accesses, RETRY and SPLIT are never issued, and `hsplit`/`hsplit_mast` are tied to 0. Ports remain present.

## Structure
- **Package `ahb_pkg`:**
  - `hresp` encodings: `RESP_OKAY`, `RESP_ERROR`, `RESP_RETRY`, `RESP_SPLIT`.
  - FSM state typedef.
  - Master-number width constant.
- **Sub-module `ahb_split_tracker`:** pending entry, latency counter and `hsplit` pulse generation. It is instantiated only under `AHB_SLV_SPLIT_EN`.
- **Memory:** inferred synchronous-write array in the top module.

## Test plan
- **Write then read, `WAIT_CYCLES` = 1:** write 32'hDEADBEEF to byte address 0x10, then read 0x10. Required: `hready` low for one cycle on each transfer, read returns 32'hDEADBEEF, `hresp` = 00.
- **ERROR response:** access byte address 0x0000_1000 with `ADDR_W` = 8. Required: RESP1 with `hready` 0 and `hresp` 01, then RESP2 with `hready` 1 and `hresp` 01; memory unchanged.
- **SPLIT and retry:** master 2 reads index 0xC4. Required: two-cycle SPLIT (11), then `hsplit` pulse with `hsplit_mast` = 2 after 16 cycles; master 2's re-issued read then completes OKAY with correct data.
- **RETRY while split pending:** with master 2's split pending, master 1 accesses index 0xC8. Required: two-cycle RETRY (10) and no change to the stored master.
- **Back-to-back pipelined transfers, `WAIT_CYCLES` = 0:** four writes to indices 0–3 followed by four reads. Required: one transfer per cycle, all data correct.
- **Reset mid-operation:**
  - Assert `hresetn` during WAIT → all outputs return to reset values immediately.
  - Assert `hresetn` with a split entry pending → no `hsplit` pulse afterwards.
